// File: rtl/sreg_wb_arbiter.sv
// Round-robin writeback arbiter in front of the scalar register file.
// One producer wins per cycle; the winning write is registered and doubles as the decode forwarding entry.
module sreg_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SRC    = 3,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_SRC-1:0]              src_valid_i,
    output logic [NUM_SRC-1:0]              src_ready_o,
    input  logic [NUM_SRC*5-1:0]            src_rd_i,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]   src_data_i,
    output logic [4:0]                      rd_addr_o,
    output logic [DATA_WIDTH-1:0]           rd_data_o,
    output logic                            reg_write_en_o,
    output logic                            fwd_valid_o,
    output logic [4:0]                      fwd_addr_o,
    output logic [DATA_WIDTH-1:0]           fwd_data_o,
    output logic [CNT_WIDTH-1:0]            wb_count_o
);

    localparam int PTR_WIDTH = $clog2(NUM_SRC);

    logic [PTR_WIDTH-1:0]  ptr_reg;
    logic [PTR_WIDTH-1:0]  ptr_next;
    logic                  grant_valid;
    logic [PTR_WIDTH-1:0]  grant_idx;
    logic [4:0]            src_rd   [NUM_SRC];
    logic [DATA_WIDTH-1:0] src_data [NUM_SRC];
    logic                  wen_reg;
    logic [4:0]            addr_reg;
    logic [DATA_WIDTH-1:0] data_reg;
    logic [CNT_WIDTH-1:0]  cnt_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign src_rd[gi]      = src_rd_i[gi*5 +: 5];
            assign src_data[gi]    = src_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
            assign src_ready_o[gi] = grant_valid && (grant_idx == PTR_WIDTH'(gi));
        end
    endgenerate

    // Scan ptr, ptr+1, ... wrapping at NUM_SRC; nothing is granted while in reset.
    always_comb begin
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            idx = int'(ptr_reg) + i;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            if (!grant_valid && rst_n && src_valid_i[idx[PTR_WIDTH-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = idx[PTR_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (grant_valid) begin
            ptr_next = (grant_idx == PTR_WIDTH'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_reg  <= '0;
            wen_reg  <= 1'b0;
            addr_reg <= '0;
            data_reg <= '0;
            cnt_reg  <= '0;
        end else begin
            ptr_reg <= ptr_next;
            wen_reg <= 1'b0;
            if (grant_valid) begin
                addr_reg <= src_rd[grant_idx];
                data_reg <= src_data[grant_idx];
                // x0 results drain the source but are never written, forwarded or counted.
                if (src_rd[grant_idx] != 5'd0) begin
                    wen_reg <= 1'b1;
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    end

    assign rd_addr_o      = addr_reg;
    assign rd_data_o      = data_reg;
    assign reg_write_en_o = wen_reg;
    assign fwd_valid_o    = wen_reg;
    assign fwd_addr_o     = addr_reg;
    assign fwd_data_o     = data_reg;
    assign wb_count_o     = cnt_reg;

endmodule

// File: tb/tb_sreg_wb_arbiter.sv
// Directed bench for sreg_wb_arbiter: expected grants and register-file writes are queued
// by the stimulus and consumed by an independent negedge monitor.
module tb_sreg_wb_arbiter;

    localparam int DW = 32;
    localparam int NS = 3;
    localparam int CW = 4;

    typedef struct {
        logic [4:0]    addr;
        logic [DW-1:0] data;
    } wr_t;

    logic                 clk;
    logic                 rst_n;
    logic [NS-1:0]        src_valid;
    logic [NS-1:0]        src_ready;
    logic [NS-1:0][4:0]   src_rd;
    logic [NS-1:0][DW-1:0] src_data;
    logic [4:0]           rd_addr;
    logic [DW-1:0]        rd_data;
    logic                 reg_write_en;
    logic                 fwd_valid;
    logic [4:0]           fwd_addr;
    logic [DW-1:0]        fwd_data;
    logic [CW-1:0]        wb_count;

    int  checks   = 0;
    int  failures = 0;
    bit  done     = 0;
    int  exp_gnt[$];
    wr_t exp_wr[$];

    sreg_wb_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(NS), .CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .src_valid_i    (src_valid),
        .src_ready_o    (src_ready),
        .src_rd_i       (src_rd),
        .src_data_i     (src_data),
        .rd_addr_o      (rd_addr),
        .rd_data_o      (rd_data),
        .reg_write_en_o (reg_write_en),
        .fwd_valid_o    (fwd_valid),
        .fwd_addr_o     (fwd_addr),
        .fwd_data_o     (fwd_data),
        .wb_count_o     (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end else begin
            $display("ok   %s value=%0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [4:0] a, input logic [DW-1:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_wr.push_back(w);
    endtask

    function automatic logic [DW-1:0] pres(input int s, input int n);
        return 32'hA000_0000 + DW'(s * 256) + DW'(n);
    endfunction

    // Monitor: every nonzero ready must match the next expected grant; every write the next expected write.
    always @(negedge clk) begin
        if (!done) begin
            if (src_ready != '0) begin
                if (exp_gnt.size() == 0) begin
                    chk("unexpected_grant", 64'(src_ready), 64'(0));
                end else begin
                    int g;
                    g = exp_gnt.pop_front();
                    chk("grant", 64'(src_ready), 64'(1) << g);
                end
            end
            if (reg_write_en) begin
                if (exp_wr.size() == 0) begin
                    chk("unexpected_write", 64'(rd_addr), 64'(0));
                end else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    chk("wr_addr", 64'(rd_addr), 64'(w.addr));
                    chk("wr_data", 64'(rd_data), 64'(w.data));
                    chk("fwd_entry", {26'd0, fwd_valid, fwd_addr, fwd_data},
                        {26'd0, 1'b1, w.addr, w.data});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with all sources valid.
        rst_n     = 1'b0;
        src_valid = 3'b111;
        for (int s = 0; s < NS; s++) begin
            src_rd[s]   = 5'(s + 1);
            src_data[s] = pres(s, 0);
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            @(negedge clk);
            chk("rst_ready", 64'(src_ready), 64'(0));
            chk("rst_outputs", {rd_addr, rd_data, reg_write_en, fwd_valid, fwd_addr, fwd_data, wb_count},
                0);
        end

        // Contention: grants 0,1,2,0,1,2; each source re-presents after acceptance.
        for (int c = 0; c < 6; c++) begin
            exp_gnt.push_back(c % 3);
            push_wr(5'(c % 3 + 1), pres(c % 3, c / 3));
        end
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            src_data[c % 3] = pres(c % 3, c / 3 + 1);
        end
        src_valid = 3'b000;
        tick();
        tick();
        @(negedge clk);
        chk("cnt_after_contention", 64'(wb_count), 64'(6));

        // Single source: src1, rd=5.
        src_valid    = 3'b010;
        src_rd[1]    = 5'd5;
        src_data[1]  = 32'hDEADBEEF;
        exp_gnt.push_back(1);
        push_wr(5'd5, 32'hDEADBEEF);
        tick();
        src_valid = 3'b000;
        tick();
        @(negedge clk);
        chk("cnt_after_single", 64'(wb_count), 64'(7));

        // x0 write from src0 (ptr=2), then src0+src2 with ptr=1: grants 2 then 0.
        src_valid   = 3'b001;
        src_rd[0]   = 5'd0;
        src_data[0] = 32'h1111_1111;
        exp_gnt.push_back(0);
        tick();
        src_valid   = 3'b101;
        src_rd[0]   = 5'd4;
        src_data[0] = 32'h4444_4444;
        src_rd[2]   = 5'd6;
        src_data[2] = 32'h6666_6666;
        exp_gnt.push_back(2);
        exp_gnt.push_back(0);
        push_wr(5'd6, 32'h6666_6666);
        push_wr(5'd4, 32'h4444_4444);
        @(negedge clk);
        chk("x0_no_wen", 64'(reg_write_en), 64'(0));
        tick();
        src_valid[2] = 1'b0;
        tick();
        src_valid[0] = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("cnt_after_x0_wrap", 64'(wb_count), 64'(9));

        // Reset mid-stream: ptr=1 so src1 (rd=7) wins, then reset the next cycle.
        src_valid   = 3'b111;
        src_rd[0]   = 5'd8;
        src_data[0] = 32'h8888_8888;
        src_rd[1]   = 5'd7;
        src_data[1] = 32'h7777_7777;
        src_rd[2]   = 5'd9;
        src_data[2] = 32'h9999_9999;
        exp_gnt.push_back(1);
        push_wr(5'd7, 32'h7777_7777);
        tick();
        src_valid[1] = 1'b0;
        rst_n        = 1'b0;
        @(negedge clk);
        chk("ready_in_reset", 64'(src_ready), 64'(0));
        exp_gnt.push_back(0);
        exp_gnt.push_back(2);
        push_wr(5'd8, 32'h8888_8888);
        push_wr(5'd9, 32'h9999_9999);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("wen_after_reset", 64'(reg_write_en), 64'(0));
        chk("cnt_after_reset", 64'(wb_count), 64'(0));
        tick();
        src_valid[0] = 1'b0;
        tick();
        src_valid[2] = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("cnt_after_pending", 64'(wb_count), 64'(2));

        // 14 more writes bring the 4-bit counter to 16, i.e. back to 0.
        src_valid   = 3'b010;
        src_rd[1]   = 5'd10;
        src_data[1] = 32'hC000_0000;
        for (int i = 0; i < 14; i++) begin
            exp_gnt.push_back(1);
            push_wr(5'(10 + i), 32'hC000_0000 + DW'(i));
        end
        for (int i = 0; i < 14; i++) begin
            tick();
            if (i < 13) begin
                src_rd[1]   = 5'(11 + i);
                src_data[1] = 32'hC000_0000 + DW'(i + 1);
            end else begin
                src_valid = 3'b000;
            end
        end
        tick();
        tick();
        @(negedge clk);
        chk("cnt_wrap", 64'(wb_count), 64'(0));
        chk("grants_left", 64'(exp_gnt.size()), 64'(0));
        chk("writes_left", 64'(exp_wr.size()), 64'(0));

        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
